// File: rtl/uart_frame_assembler.sv
// Byte/word bridge between a UART byte transceiver and the command layer.
// The RX side packs bytes into frames (MSB first); the TX side serialises response words.
module uart_frame_assembler #(
  parameter int FIFO_SIZE      = 3,
  parameter int BITWIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          CLK_SYS,
  input  logic                          RSTN,
  input  logic                          RX_VALID,
  input  logic [BITWIDTH-1:0]           RX_DATA,
  input  logic                          TX_RDY,
  output logic                          TX_START,
  output logic [BITWIDTH-1:0]           TX_DATA,
  output logic [BITWIDTH*FIFO_SIZE-1:0] FRAME_OUT,
  output logic                          FRAME_VALID,
  input  logic [BITWIDTH*FIFO_SIZE-1:0] RESP_IN,
  input  logic                          RESP_VALID,
  output logic                          RESP_READY,
  output logic                          TIMEOUT_PULSE
);

  localparam int FW = BITWIDTH * FIFO_SIZE;
  localparam int PW = FW - BITWIDTH;
  localparam int CW = $clog2(FIFO_SIZE);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(FIFO_SIZE - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} tx_state_t;

  logic [PW-1:0] sreg;
  logic [FW-1:0] rx_word;
  logic [CW-1:0] rcnt;
  logic [TW-1:0] timer;

  tx_state_t     state, state_next;
  logic [FW-1:0] tx_word, tx_word_next;
  logic [CW-1:0] tcnt, tcnt_next;
  logic          tx_start_next;
  logic [BITWIDTH-1:0] tx_data_next;
  logic          resp_ready_next;

  // Only the earlier FIFO_SIZE-1 bytes are stored; the newest byte comes straight from RX_DATA.
  assign rx_word = {sreg, RX_DATA};

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      sreg          <= '0;
      rcnt          <= '0;
      timer         <= '0;
      FRAME_OUT     <= '0;
      FRAME_VALID   <= 1'b0;
      TIMEOUT_PULSE <= 1'b0;
    end else begin
      FRAME_VALID   <= 1'b0;
      TIMEOUT_PULSE <= 1'b0;
      if (RX_VALID) begin
        sreg  <= rx_word[PW-1:0];
        timer <= '0;
        if (rcnt == LAST_BYTE) begin
          rcnt        <= '0;
          FRAME_OUT   <= rx_word;
          FRAME_VALID <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end else if (rcnt != '0) begin
        // A byte arriving on the expiry cycle wins over the timeout (handled above).
        if (timer == TIMER_MAX) begin
          rcnt          <= '0;
          timer         <= '0;
          TIMEOUT_PULSE <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      state      <= IDLE;
      tx_word    <= '0;
      tcnt       <= '0;
      TX_START   <= 1'b0;
      TX_DATA    <= '0;
      RESP_READY <= 1'b0;
    end else begin
      state      <= state_next;
      tx_word    <= tx_word_next;
      tcnt       <= tcnt_next;
      TX_START   <= tx_start_next;
      TX_DATA    <= tx_data_next;
      RESP_READY <= resp_ready_next;
    end
  end

  always_comb begin
    state_next      = state;
    tx_word_next    = tx_word;
    tcnt_next       = tcnt;
    tx_start_next   = 1'b0;
    tx_data_next    = TX_DATA;
    resp_ready_next = RESP_READY;
    case (state)
      IDLE: begin
        resp_ready_next = 1'b1;
        if (RESP_READY && RESP_VALID) begin
          tx_word_next    = RESP_IN;
          tcnt_next       = '0;
          resp_ready_next = 1'b0;
          state_next      = LOAD;
        end
      end
      LOAD: begin
        if (TX_RDY) begin
          tx_data_next  = tx_word[FW-1 -: BITWIDTH];
          tx_start_next = 1'b1;
          state_next    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!TX_RDY) state_next = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        // Only a full low-then-high cycle of TX_RDY counts as a finished byte.
        if (TX_RDY) begin
          tx_word_next = tx_word << BITWIDTH;
          tcnt_next    = tcnt + 1'b1;
          if (tcnt == LAST_BYTE) begin
            state_next      = IDLE;
            resp_ready_next = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomised bench for uart_frame_assembler: the RX scoreboard is built from byte arrival times,
// and the TX side is checked against a transmitter model with a programmable busy time.
module tb_uart_frame_assembler;

  localparam int FS = 3;
  localparam int BW = 8;
  localparam int TO = 50;
  localparam int FW = FS * BW;

  logic          CLK_SYS = 1'b0;
  logic          RSTN = 1'b0;
  logic          RX_VALID = 1'b0;
  logic [BW-1:0] RX_DATA = '0;
  logic          TX_RDY = 1'b1;
  logic          TX_START;
  logic [BW-1:0] TX_DATA;
  logic [FW-1:0] FRAME_OUT;
  logic          FRAME_VALID;
  logic [FW-1:0] RESP_IN = '0;
  logic          RESP_VALID = 1'b0;
  logic          RESP_READY;
  logic          TIMEOUT_PULSE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int            fv_cyc_q[$];
  logic [FW-1:0] fv_val_q[$];
  int            to_q[$];
  logic [BW-1:0] ts_q[$];
  int            acc_q[$];
  logic [BW-1:0] byte_q[$];
  int            busy = 0;
  int            busy_len = 20;

  uart_frame_assembler #(.FIFO_SIZE(FS), .BITWIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_SYS(CLK_SYS), .RSTN(RSTN), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .TX_RDY(TX_RDY), .TX_START(TX_START), .TX_DATA(TX_DATA),
    .FRAME_OUT(FRAME_OUT), .FRAME_VALID(FRAME_VALID),
    .RESP_IN(RESP_IN), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .TIMEOUT_PULSE(TIMEOUT_PULSE)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  always @(posedge CLK_SYS) cyc <= cyc + 1;

  // Event monitor plus transmitter model: TX_RDY drops for busy_len cycles after each start.
  always @(negedge CLK_SYS) begin
    if (FRAME_VALID) begin
      fv_cyc_q.push_back(cyc);
      fv_val_q.push_back(FRAME_OUT);
    end
    if (TIMEOUT_PULSE) to_q.push_back(cyc);
    if (TX_START) begin
      ts_q.push_back(TX_DATA);
      busy = busy_len;
      TX_RDY = 1'b0;
    end else if (busy > 0) begin
      busy = busy - 1;
      if (busy == 0) TX_RDY = 1'b1;
    end
  end

  task automatic step();
    @(negedge CLK_SYS);
    #1;
  endtask

  task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic rx_clear();
    acc_q.delete(); byte_q.delete();
    fv_cyc_q.delete(); fv_val_q.delete(); to_q.delete();
  endtask

  task automatic rx_send(input logic [BW-1:0] b, input int gap);
    RX_VALID = 1'b0;
    repeat (gap) step();
    RX_VALID = 1'b1;
    RX_DATA  = b;
    acc_q.push_back(cyc + 1);
    byte_q.push_back(b);
    step();
    RX_VALID = 1'b0;
  endtask

  // Reference: bytes accumulate into a frame unless more than TO cycles pass between arrivals.
  task automatic check_rx(input string name, output logic [FW-1:0] last_frame);
    int e_fc[$];
    logic [FW-1:0] e_fv[$];
    int e_to[$];
    int part, last;
    logic [FW-1:0] val;
    part = 0; last = 0; val = '0; last_frame = '0;
    for (int i = 0; i < acc_q.size(); i++) begin
      if (part > 0 && acc_q[i] - last > TO) begin
        e_to.push_back(last + TO);
        part = 0;
      end
      val = (part == 0) ? FW'(byte_q[i]) : FW'((val << BW) | FW'(byte_q[i]));
      part++;
      if (part == FS) begin
        e_fc.push_back(acc_q[i]);
        e_fv.push_back(val);
        last_frame = val;
        part = 0;
      end
      last = acc_q[i];
    end
    if (part > 0) e_to.push_back(last + TO);
    chk({name, "_frame_count"}, FW'(fv_cyc_q.size()), FW'(e_fc.size()));
    for (int i = 0; i < e_fc.size() && i < fv_cyc_q.size(); i++) begin
      chk({name, "_frame_cycle"}, FW'(fv_cyc_q[i]), FW'(e_fc[i]));
      chk({name, "_frame_value"}, fv_val_q[i], e_fv[i]);
    end
    chk({name, "_timeout_count"}, FW'(to_q.size()), FW'(e_to.size()));
    for (int i = 0; i < e_to.size() && i < to_q.size(); i++)
      chk({name, "_timeout_cycle"}, FW'(to_q[i]), FW'(e_to[i]));
  endtask

  task automatic tx_send(input logic [FW-1:0] word, input string name);
    int base, guard, ready_hi;
    logic done;
    guard = 0;
    while (!RESP_READY && guard < 200) begin step(); guard++; end
    chk({name, "_ready_before"}, FW'(RESP_READY), FW'(1));
    base = ts_q.size();
    RESP_IN = word;
    RESP_VALID = 1'b1;
    step();
    RESP_VALID = 1'b0;
    RESP_IN = FW'($urandom);
    guard = 0; ready_hi = 0;
    do begin
      if (RESP_READY) ready_hi++;
      done = (ts_q.size() - base >= FS) && TX_RDY;
      if (!done) begin step(); guard++; end
    end while (!done && guard < 3000);
    chk({name, "_completed_in_budget"}, FW'(done), FW'(1));
    chk({name, "_ready_low_cycles"}, FW'(ready_hi), FW'(0));
    step();
    chk({name, "_ready_after"}, FW'(RESP_READY), FW'(1));
    repeat (5) step();
    chk({name, "_start_count"}, FW'(ts_q.size() - base), FW'(FS));
    for (int i = 0; i < FS && base + i < ts_q.size(); i++)
      chk({name, "_tx_byte"}, FW'(ts_q[base + i]), FW'(BW'(word >> (BW * (FS - 1 - i)))));
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    rx_clear();
    for (int i = 0; i < 6; i++) begin
      RX_VALID = i[0];
      RX_DATA  = BW'($urandom);
      step();
    end
    RX_VALID = 1'b0;
    chk("reset_frame_out", FRAME_OUT, '0);
    chk("reset_frame_valid", FW'(FRAME_VALID), '0);
    chk("reset_timeout", FW'(TIMEOUT_PULSE), '0);
    chk("reset_tx_start", FW'(TX_START), '0);
    chk("reset_tx_data", FW'(TX_DATA), '0);
    chk("reset_resp_ready", FW'(RESP_READY), '0);
    chk("reset_no_frames", FW'(fv_cyc_q.size()), '0);
    RSTN = 1'b1;
    chk("resp_ready_before_edge", FW'(RESP_READY), '0);
    step();
    chk("resp_ready_after_release", FW'(RESP_READY), FW'(1));
  endtask

  task automatic test_frame();
    logic [FW-1:0] lf;
    rx_clear();
    rx_send(8'hA5, 0);
    rx_send(8'h3C, 9);
    rx_send(8'h0F, 9);
    repeat (TO + 5) step();
    check_rx("frame", lf);
    chk("frame_directed_value", lf, 24'hA53C0F);
    chk("frame_out_held", FRAME_OUT, 24'hA53C0F);
  endtask

  task automatic test_timeout();
    logic [FW-1:0] lf;
    rx_clear();
    rx_send(8'h11, 0);
    rx_send(8'h22, 3);
    rx_send(8'h33, 60);
    rx_send(8'h44, 2);
    rx_send(8'h55, 2);
    repeat (TO + 5) step();
    check_rx("timeout", lf);
    chk("timeout_refill_value", FRAME_OUT, 24'h334455);
  endtask

  task automatic test_expiry_edge();
    logic [FW-1:0] lf;
    logic [BW-1:0] b0, b1, b2;
    rx_clear();
    b0 = BW'($urandom); b1 = BW'($urandom); b2 = BW'($urandom);
    rx_send(b0, 1);
    rx_send(b1, 4);
    rx_send(b2, TO - 1);
    repeat (TO + 5) step();
    check_rx("expiry_edge", lf);
    chk("expiry_edge_no_timeout", FW'(to_q.size()), '0);
  endtask

  task automatic test_rx_random();
    logic [FW-1:0] lf;
    int gap, r;
    rx_clear();
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      gap = (r == 0) ? TO - 1 : (r == 1) ? TO : (r == 2) ? TO + 7 : int'($urandom_range(0, 4));
      rx_send(BW'($urandom), gap);
    end
    repeat (TO + 5) step();
    check_rx("rx_random", lf);
  endtask

  task automatic test_tx();
    busy_len = 20;
    tx_send(24'hDEADBE, "tx_deadbe");
    for (int i = 0; i < 3; i++) begin
      busy_len = int'($urandom_range(1, 6));
      tx_send(FW'($urandom), "tx_random");
    end
    busy_len = 20;
  endtask

  task automatic test_full_duplex();
    logic [FW-1:0] lf;
    rx_clear();
    busy_len = 20;
    fork
      begin
        rx_send(8'h01, 5);
        rx_send(8'h02, 15);
        rx_send(8'h03, 15);
      end
      tx_send(24'hDEADBE, "duplex_tx");
    join
    repeat (TO + 5) step();
    check_rx("duplex_rx", lf);
    chk("duplex_rx_value", lf, 24'h010203);
  endtask

  task automatic test_reset_mid_tx();
    int base, guard;
    busy_len = 20;
    guard = 0;
    while (!RESP_READY && guard < 200) begin step(); guard++; end
    base = ts_q.size();
    RESP_IN = 24'hDEADBE;
    RESP_VALID = 1'b1;
    step();
    RESP_VALID = 1'b0;
    guard = 0;
    while (ts_q.size() - base < 2 && guard < 500) begin step(); guard++; end
    chk("midtx_second_start_seen", FW'(ts_q.size() - base), FW'(2));
    RSTN = 1'b0;
    step();
    chk("midtx_reset_tx_data", FW'(TX_DATA), '0);
    chk("midtx_reset_ready", FW'(RESP_READY), '0);
    repeat (2) step();
    RSTN = 1'b1;
    repeat (100) step();
    chk("midtx_no_third_start", FW'(ts_q.size() - base), FW'(2));
    chk("midtx_back_to_idle", FW'(RESP_READY), FW'(1));
    tx_send(FW'($urandom), "post_reset_tx");
  endtask

  initial begin
    step();
    test_reset();
    test_frame();
    test_timeout();
    test_expiry_edge();
    test_rx_random();
    test_tx();
    test_full_duplex();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
